tty_txq: RTL

TTY_TXQ -- requirements
Module: tty_txq

---
 rtl/tty_txq.sv | 101 ++++++++++
 1 files changed

// File: rtl/tty_txq.sv
// tty_txq: memory-mapped 8N1 serial transmitter with TX FIFO; status register built only with TTY_TXQ_STATUS_EN
module tty_txq #(
  parameter int          DIV   = 400,
  parameter int          DEPTH = 8,
  parameter logic [31:0] BASE  = 32'h3000
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] addr,
  input  logic        valid,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        tx,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [15:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic hit_data, hit_stat, full, accept, push, pop;
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];
  assign hit_data = valid && addr == BASE;
  assign hit_stat = valid && addr == BASE + 32'hC;
  assign full = count == (AW+1)'(DEPTH);
  assign accept = (hit_data || hit_stat) && !ready && !(write && hit_data && full);
  assign push = accept && write && hit_data;
  assign pop = state == IDLE && count != '0;
  assign busy = count != '0 || state != IDLE;
  // completion pulse; the pulse cycle itself blocks a new accept
  always_ff @(posedge clk) begin
    if (!rstb) ready <= 1'b0;
    else ready <= accept;
  end
`ifdef TTY_TXQ_STATUS_EN
  // status load returns busy and fill level captured at accept
  always_ff @(posedge clk) begin
    if (!rstb) rdata <= 32'd0;
    else rdata <= (accept && !write && hit_stat) ? {16'd0, 7'd0, busy, 2'd0, 6'(count)} : 32'd0;
  end
`else
  assign rdata = 32'd0;
`endif
  // fifo storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata[7:0];
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // shifter: start bit, 8 data bits LSB first, stop bit, each DIV cycles
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx <= 1'b1;
    end else begin
      case (state)
        IDLE: if (pop) begin
          state <= START;
          shift <= mem[rd_ptr];
          div_cnt <= DIV_M1;
          tx <= 1'b0;
        end
        START: if (div_cnt == '0) begin
          state <= DATA;
          div_cnt <= DIV_M1;
          tx <= shift[0];
        end else div_cnt <= div_cnt - 16'd1;
        DATA: if (div_cnt == '0) begin
          div_cnt <= DIV_M1;
          bit_cnt <= bit_cnt + 3'd1;
          shift <= shift >> 1;
          state <= bit_cnt == 3'd7 ? STOP : DATA;
          tx <= bit_cnt == 3'd7 ? 1'b1 : shift[1];
        end else div_cnt <= div_cnt - 16'd1;
        STOP: if (div_cnt == '0) state <= IDLE;
        else div_cnt <= div_cnt - 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
